ultrasonido_scheduler: RTL and testbench

Round-robin measurement scheduler for up to N_SENS HC-SR04-style ultrasonic sensors that share one echo-timing engine. It fires one sensor's trigger at a time and times that sensor's echo pulse. It enforces a hold-off between pings to avoid acoustic crosstalk, then publishes the echo width, a timeout flag and a per-sensor "near" flag. It sits between the sensor pins and the game/LED logic, and replaces per-sensor push-button-triggered measurement with continuous autonomous polling.

---
 rtl/ultrasonido_scheduler.sv | 157 +++++++++++++++
 tb/tb_ultrasonido_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonido_scheduler.sv
// Round-robin ping scheduler: fires one ultrasonic sensor at a time, times its echo, then holds off.
// Latency: meas_valid one clk after the synced echo falls (3-4 clk after the raw pin falls).
// Backpressure: none; results are a one-cycle strobe with sens_id/echo_cycles/meas_timeout held until the next result.
// Ports: clk, reset (sync, active-high), enable (keep polling), echo[N_SENS] (raw async pins),
//        trigger[N_SENS] (one-hot or zero), busy, sens_id, echo_cycles, meas_valid, meas_timeout, near[N_SENS].
module ultrasonido_scheduler #(
  parameter int N_SENS      = 2,
  parameter int CNT_W       = 22,
  parameter int TRIG_CYC    = 500,
  parameter int TIMEOUT_CYC = 900000,
  parameter int HOLDOFF_CYC = 3000000,
  parameter int NEAR_CYC    = 30000,
  localparam int ID_W       = (N_SENS > 1) ? $clog2(N_SENS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_SENS-1:0] echo,
  output logic [N_SENS-1:0] trigger,
  output logic              busy,
  output logic [ID_W-1:0]   sens_id,
  output logic [CNT_W-1:0]  echo_cycles,
  output logic              meas_valid,
  output logic              meas_timeout,
  output logic [N_SENS-1:0] near
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_ECHO,
    S_MEASURE,
    S_HOLDOFF
  } state_t;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] MEAS_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] NEAR_LIM  = CNT_W'(NEAR_CYC);
  localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(N_SENS - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ID_W-1:0]   id, id_nxt;
  logic [N_SENS-1:0] sync1, sync2;
  logic              echo_s, echo_d;
  logic              res_fire, res_to;

  // Only the sensor being served is looked at; the others are pure crosstalk.
  assign echo_s = sync2[id];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      id    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      id    <= id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    id_nxt    = id;
    res_fire  = 1'b0;
    res_to    = 1'b0;
    trigger   = '0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nxt = S_TRIG;
          cnt_nxt   = '0;
        end
      end
      S_TRIG: begin
        trigger[id] = 1'b1;
        if (cnt == TRIG_LAST) begin
          state_nxt = S_WAIT_ECHO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WAIT_ECHO: begin
        // echo_d tracks the served sensor through TRIG, so a level already
        // high on entry never looks like a rise.
        if (echo_s && !echo_d) begin
          state_nxt = S_MEASURE;
          cnt_nxt   = CNT_W'(1);
        end else if (cnt == WAIT_LAST) begin
          res_fire  = 1'b1;
          res_to    = 1'b1;
          state_nxt = S_HOLDOFF;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_MEASURE: begin
        // The limit wins over a simultaneous fall: a full TIMEOUT_CYC-wide
        // echo is reported as a timeout, so valid widths stay below it.
        if (cnt == MEAS_MAX) begin
          res_fire  = 1'b1;
          res_to    = 1'b1;
          state_nxt = S_HOLDOFF;
          cnt_nxt   = '0;
        end else if (!echo_s) begin
          res_fire  = 1'b1;
          state_nxt = S_HOLDOFF;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          cnt_nxt   = '0;
          id_nxt    = (id == ID_LAST) ? '0 : id + 1'b1;
          state_nxt = enable ? S_TRIG : S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1        <= '0;
      sync2        <= '0;
      echo_d       <= 1'b0;
      meas_valid   <= 1'b0;
      meas_timeout <= 1'b0;
      echo_cycles  <= '0;
      sens_id      <= '0;
      near         <= '0;
    end else begin
      sync1      <= echo;
      sync2      <= sync1;
      echo_d     <= echo_s;
      meas_valid <= res_fire;
      if (res_fire) begin
        sens_id      <= id;
        meas_timeout <= res_to;
        echo_cycles  <= res_to ? MEAS_MAX : cnt;
        near[id]     <= !res_to && (cnt < NEAR_LIM);
      end
    end
  end

endmodule

// File: tb/tb_ultrasonido_scheduler.sv
// Randomized ping bench: each ping's expected result comes from the echo
// shape (delay, width) and is queued; a negedge monitor pops on meas_valid.
module tb_ultrasonido_scheduler;

  localparam int NS = 2;
  localparam int TRIG = 5;
  localparam int TMO = 100;
  localparam int HOLD = 20;
  localparam int NEARC = 30;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [NS-1:0] echo = '0;
  logic [NS-1:0] trigger;
  logic          busy;
  logic [0:0]    sens_id;
  logic [21:0]   echo_cycles;
  logic          meas_valid;
  logic          meas_timeout;
  logic [NS-1:0] near;

  ultrasonido_scheduler #(
    .N_SENS(NS), .CNT_W(22), .TRIG_CYC(TRIG), .TIMEOUT_CYC(TMO),
    .HOLDOFF_CYC(HOLD), .NEAR_CYC(NEARC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo(echo),
    .trigger(trigger), .busy(busy), .sens_id(sens_id),
    .echo_cycles(echo_cycles), .meas_valid(meas_valid),
    .meas_timeout(meas_timeout), .near(near)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sid;
    int          to;
    int          cycles;
    logic [1:0]  nr;
    int          lat;
    int          t0;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         last_valid_cyc = 0;
  bit         spacing_armed = 1'b0;
  logic [1:0] near_m = '0;
  int         next_id = 0;
  logic [NS-1:0] trig_prev = '0;
  int         trig_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_trigger"}, trigger, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_meas_valid"}, meas_valid, 0);
    chk({tag, "_meas_timeout"}, meas_timeout, 0);
    chk({tag, "_echo_cycles"}, echo_cycles, 0);
    chk({tag, "_sens_id"}, sens_id, 0);
    chk({tag, "_near"}, near, 0);
  endtask

  // Monitor: trigger shape, hold-off spacing and scoreboard comparison.
  always @(negedge clk) begin
    if (reset) begin
      trig_prev = '0;
    end else begin
      if (trigger != 0) chk("trigger_onehot", $countones(trigger), 1);
      if (trigger != 0 && trig_prev == 0) begin
        trig_len = 0;
        if (spacing_armed) chk("holdoff_gap", cyc - last_valid_cyc, HOLD);
        spacing_armed = 1'b0;
      end
      if (trigger != 0) trig_len++;
      if (trigger == 0 && trig_prev != 0) chk("trigger_len", trig_len, TRIG);
      trig_prev = trigger;
      if (meas_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_meas_valid: got sens_id=%0d cycles=%0d, expected none", sens_id, echo_cycles);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sens_id", sens_id, e.sid);
          chk("echo_cycles", echo_cycles, e.cycles);
          chk("meas_timeout", meas_timeout, e.to);
          chk("near", near, e.nr);
          chk("result_latency", cyc - e.t0, e.lat);
        end
        last_valid_cyc = cyc;
        spacing_armed = 1'b1;
      end
    end
  end

  // mode 0: echo pulse of width w starting d cycles after trigger falls
  // mode 1: no echo at all; mode 2: echo already high before the trigger
  task automatic do_ping(input int sid, input int mode, input int d, input int w,
                         input bit xt, input bit drop_en);
    int   len;
    bit   ok;
    exp_t e;
    if (mode == 2) echo[sid] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (trigger[sid]) begin ok = 1'b1; break; end
    end
    if (!ok) begin fail_now("trigger_rise_wait"); echo = '0; return; end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!trigger[sid]) begin ok = 1'b1; break; end
    end
    if (!ok) begin fail_now("trigger_fall_wait"); echo = '0; return; end

    // Reference: synced echo rises d+2 cycles into the 100-cycle listen
    // window; a high phase of TMO cycles or more is a timeout.
    e.sid = sid;
    e.t0  = cyc;
    if (mode == 0 && d + 2 <= TMO - 1 && w < TMO) begin
      e.to = 0; e.cycles = w; e.lat = d + w + 3;
      near_m[sid] = (w < NEARC);
    end else if (mode == 0 && d + 2 <= TMO - 1) begin
      e.to = 1; e.cycles = TMO; e.lat = d + 3 + TMO;
      near_m[sid] = 1'b0;
    end else begin
      e.to = 1; e.cycles = TMO; e.lat = TMO;
      near_m[sid] = 1'b0;
    end
    e.nr = near_m;
    q.push_back(e);

    len = (mode == 0) ? d + w : (mode == 1) ? 90 : 110;
    for (int k = 0; k < len; k++) begin
      echo[sid]     = (mode == 2) ? 1'b1 : (mode == 0 && k >= d && k < d + w);
      echo[1 - sid] = xt ? 1'($urandom_range(0, 1)) : 1'b0;
      if (drop_en && k == d / 2) enable = 1'b0;
      @(negedge clk);
    end
    echo = '0;
    next_id = (sid + 1) % NS;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r, d, w, mode;
    bit  ok;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    enable = 1'b1;

    do_ping(0, 0, 10, 40, 1'b0, 1'b0);   // far target on sensor 0
    do_ping(1, 0, 3, 12, 1'b0, 1'b0);    // near target on sensor 1
    do_ping(0, 1, 0, 0, 1'b0, 1'b0);     // no echo
    do_ping(1, 2, 0, 0, 1'b0, 1'b0);     // stale echo held through trigger
    do_ping(0, 0, 5, 100, 1'b0, 1'b0);   // exactly TMO high cycles
    do_ping(1, 0, 4, 99, 1'b0, 1'b0);    // longest valid width
    do_ping(0, 0, 7, 25, 1'b1, 1'b0);    // crosstalk on sensor 1

    for (int p = 0; p < 40; p++) begin
      r = $urandom_range(0, 5);
      if (r <= 2) begin
        mode = 0; d = $urandom_range(0, 40); w = $urandom_range(1, 60);
      end else if (r == 3) begin
        mode = 0; d = $urandom_range(0, 10); w = $urandom_range(99, 110);
      end else begin
        mode = r - 3; d = 0; w = 0;
      end
      do_ping(next_id, mode, d, w, 1'($urandom_range(0, 1)), 1'b0);
    end

    // enable dropped mid-listen: result still reported, then park in IDLE
    do_ping(next_id, 0, 20, 15, 1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("idle_wait");
    else chk("idle_after_holdoff", cyc - last_valid_cyc, HOLD);
    repeat (5) @(negedge clk);
    chk("parked_busy", busy, 0);
    chk("parked_trigger", trigger, 0);
    spacing_armed = 1'b0;
    enable = 1'b1;

    // reset pulsed mid-MEASURE: no result, everything cleared
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (trigger[next_id]) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("abort_trigger_wait");
    while (trigger != 0) @(negedge clk);
    echo[next_id] = 1'b1;
    repeat (15) @(negedge clk);
    enable = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("abort");
    reset = 1'b0;
    echo = '0;
    near_m = '0;
    next_id = 0;
    spacing_armed = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    enable = 1'b1;
    do_ping(0, 0, 2, 8, 1'b0, 1'b0);
    do_ping(1, 0, 6, 45, 1'b1, 1'b0);

    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail_now("drain_scoreboard");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
